// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
// Holds the FSM state enum, opcodes, datapath select codes and the ImmSrc helper.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_SW:   immSrcFor = IMM_S;
      OP_BEQ:  immSrcFor = IMM_B;
      OP_JAL:  immSrcFor = IMM_J;
      default: immSrcFor = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction fields onto the ALUControl code.
module multicycle_alu_dec
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o
);

  // Only R-type (Op[5] set) may select sub through funct7; I-type add ignores it.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I-subset datapath.
// Outputs are decoded from the state register; mem_ready and Zero feed a few strobes.
module multicycle_controller
  import rv_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic [1:0]       aluOp;
  logic             unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    aluOp      = ALUOP_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        aluOp      = ALUOP_SUB;
        PCWrite    = Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset is asynchronous, so strobes must be killed combinationally too.
    if (rst) begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign ImmSrc  = immSrcFor(Op);
  assign instret = instret_q;

  multicycle_alu_dec uAluDec (
    .alu_op_i      (aluOp),
    .funct3_i      (funct3),
    .op5_i         (Op[5]),
    .funct7_5_i    (funct7[5]),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (instret narrowed to 4 bits
// so that the wrap-around is reachable in a short run).
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic          clk, rst;
  logic [6:0]    Op, funct7;
  logic [2:0]    funct3;
  logic          Zero, mem_ready;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, instr_done;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]    ALUControl;
  logic [CW-1:0] instret;

  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] expCount;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
    .instr_done(instr_done), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected output vector: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal,instr_done}
  function automatic logic [17:0] ev(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                     logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [1:0] imm, logic [2:0] alu, logic ill, logic done);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, done};
  endfunction

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic z, logic r, logic [17:0] e);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = r; v.exp = e;
    return v;
  endfunction

  // FETCH, DECODE, EXECUTE(R/I), ALUWB for one ALU instruction with zero wait states.
  task automatic addAlu(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [2:0] alu);
    logic [1:0] sb;
    sb = (op == IT) ? 2'b01 : 2'b00;
    vecs.push_back(mk({n, " fetch"},  op, f3, f7, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000,0,0)));
    vecs.push_back(mk({n, " decode"}, op, f3, f7, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000,0,0)));
    vecs.push_back(mk({n, " exec"},   op, f3, f7, 0, 1, ev(0,0,0,0,0, 2'b00,2'b10,sb,   2'b00, alu,   0,0)));
    vecs.push_back(mk({n, " aluwb"},  op, f3, f7, 0, 1, ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000,0,1)));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    Op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.z; mem_ready = v.rdy;
    #1;
  endtask

  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    logic [17:0] got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, illegal, instr_done};
    check(v.name, 32'(got), 32'(v.exp));
    check({v.name, " instret"}, 32'(instret), 32'(expCount));
    if (v.exp[0]) expCount = expCount + 1'b1;
  endtask

  task automatic runVecs();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
  endtask

  initial begin
    rst = 1'b1; Op = BAD; funct3 = 3'b000; funct7 = 7'b0; Zero = 1'b0; mem_ready = 1'b1;
    expCount = '0;
    #3;
    check("reset strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal, instr_done}), 32'h0);
    check("reset instret", 32'(instret), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk("lw fetch",   LW, 3'b010, 7'h00, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000,0,0)));
    vecs.push_back(mk("lw decode",  LW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000,0,0)));
    vecs.push_back(mk("lw memadr",  LW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000,0,0)));
    vecs.push_back(mk("lw memread", LW, 3'b010, 7'h00, 0, 1, ev(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000,0,0)));
    vecs.push_back(mk("lw memwb",   LW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000,0,1)));
    vecs.push_back(mk("sw fetch stall", SW, 3'b010, 7'h00, 0, 0, ev(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw fetch",   SW, 3'b010, 7'h00, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw decode",  SW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw memadr",  SW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000,0,0)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk("sw memwrite wait", SW, 3'b010, 7'h00, 0, 0, ev(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw memwrite done", SW, 3'b010, 7'h00, 0, 1, ev(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000,0,1)));
    addAlu("r sub", RT, 3'b000, 7'b0100000, 3'b001);
    addAlu("r add", RT, 3'b000, 7'b0000000, 3'b000);
    addAlu("r or",  RT, 3'b110, 7'b0000000, 3'b011);
    addAlu("r slt", RT, 3'b010, 7'b0000000, 3'b101);
    addAlu("i add f7b5", IT, 3'b000, 7'b0100000, 3'b000);
    addAlu("i and", IT, 3'b111, 7'b0000000, 3'b010);
    for (int z = 1; z >= 0; z--) begin
      vecs.push_back(mk("beq fetch",  BQ, 3'b000, 7'h00, 1'(z), 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10, 3'b000,0,0)));
      vecs.push_back(mk("beq decode", BQ, 3'b000, 7'h00, 1'(z), 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000,0,0)));
      vecs.push_back(mk("beq exec",   BQ, 3'b000, 7'h00, 1'(z), 1, ev(1'(z),0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001,0,1)));
    end
    vecs.push_back(mk("ill fetch",  BAD, 3'b000, 7'h00, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 3'b000,0,0)));
    vecs.push_back(mk("ill decode", BAD, 3'b000, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000,1,0)));
    vecs.push_back(mk("jal fetch",  JL, 3'b000, 7'h00, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b11, 3'b000,0,0)));
    vecs.push_back(mk("jal decode", JL, 3'b000, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11, 3'b000,0,0)));
    vecs.push_back(mk("jal exec",   JL, 3'b000, 7'h00, 0, 1, ev(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11, 3'b000,0,0)));
    vecs.push_back(mk("jal aluwb",  JL, 3'b000, 7'h00, 0, 1, ev(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 3'b000,0,1)));
    vecs.push_back(mk("sw2 fetch",  SW, 3'b010, 7'h00, 0, 1, ev(1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw2 decode", SW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw2 memadr", SW, 3'b010, 7'h00, 0, 1, ev(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000,0,0)));
    vecs.push_back(mk("sw2 memwrite wait", SW, 3'b010, 7'h00, 0, 0, ev(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000,0,0)));
    runVecs();

    // Abort the pending store with an asynchronous reset in the middle of the low phase.
    check("pre-reset instret", 32'(instret), 32'd11);
    #2;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("abort strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal, instr_done}), 32'h0);
    check("abort instret", 32'(instret), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expCount = '0;
    #1;
    check("post-reset fetch rdy1", 32'({IRWrite, PCWrite, ALUSrcB, ResultSrc}), 32'b11_10_10);
    mem_ready = 1'b0;
    #1;
    check("post-reset fetch rdy0", 32'({IRWrite, PCWrite, ALUSrcB, ResultSrc}), 32'b00_10_10);

    // Sixteen retirements must bring a 4-bit instret back to zero.
    vecs.delete();
    for (int k = 0; k < 16; k++) addAlu("wrap add", RT, 3'b000, 7'b0000000, 3'b000);
    runVecs();
    @(negedge clk);
    Op = RT; mem_ready = 1'b0;
    #1;
    check("wrap instret", 32'(instret), 32'h0);
    check("wrap back in fetch", 32'({IRWrite, ALUSrcB, ResultSrc}), 32'b0_10_10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
